uart_spi: RTL and testbench
===========================

# uart_spi

Tiny-Tapeout-style I/O block with two independent serial engines. A UART receiver/transmitter pair echoes the last received byte. A 16-bit SPI shift engine generates its own SCLK, captures MOSI and echoes the last captured word on MISO. Both share a 2-bit rate select and sit directly behind the chip pins.

## Interface
- No parameters; rate tables are constants in `uart_spi_pkg`.
- `clk` in 1: system clock, 50 MHz nominal.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `ena` in 1: always 1, ignored.
- `ui_in` in 8:
  - [1:0] freq_control
  - [2] uart_rx
  - [3] uart_tx_start
  - [4] cs_bar, SPI launch enable; 1 = allowed
  - [5] mosi
  - [6] unused
  - [7] loopback
- `uio_in` in 8: [0] spi_rx_start, [1] spi_tx_start, rest unused.
- `uo_out` out 8:
  - [0] uart_tx
  - [1] miso
  - [2] uart_rx_valid
  - [3] uart_tx_done
  - [4] spi_rx_valid
  - [5] spi_tx_done
  - [6] sclk
  - [7] spi_busy
- `uio_out` out 8: constant 0.
- `uio_oe` out 8: constant 0.

## Operation
- All `ui_in`/`uio_in` bits pass through 2-flop synchronizers. Start inputs are level-sampled; a single-cycle pulse suffices.
- freq_control is latched at each frame/transfer start.
  - UART bit period (clk cycles): 00=5208, 01=434, 10=50, 11=25.
  - SCLK half-period (clk cycles): 00=8, 01=1, 10=4, 11=2.
- UART RX:
  - Falling edge on rx (idle high) starts a frame and clears uart_rx_valid.
  - Samples at mid-bit. Frame is start, 8 data LSB first, stop.
  - At mid-stop-bit, stores the byte in rx_byte and sets uart_rx_valid (sticky).
  - Bad stop bit (0) discards the frame; uart_rx_valid stays 0.
- UART TX:
  - uart_tx_start while idle sends rx_byte: start, 8 data LSB first, stop, one bit period each.
  - Clears uart_tx_done at start; sets it (sticky) at end of stop bit.
  - Start while busy is ignored.
- SPI engine:
  - Launches only if (spi_rx_start | spi_tx_start) & cs_bar & idle. It latches which of rx/tx were requested; both together gives full duplex.
  - spi_busy=1 for the transfer. Clears the requested valid/done flag at launch.
  - SCLK idles high; 16 cycles of fall-then-rise.
  - MISO changes on each falling SCLK, MSB first, from tx_word. MOSI is sampled on each rising SCLK into a shift register.
  - After the 16th rising edge SCLK stays high and spi_busy=0.
  - rx request: shift register → rx_word, spi_rx_valid=1 (sticky).
  - tx request: spi_tx_done=1 (sticky).
  - tx_word is a copy of rx_word, updated whenever rx_word updates. MISO idles 0.
- loopback=1: UART RX input is internally the uart_tx output, and the SPI MOSI sample is internally MISO. Pins are ignored.
- Reset values: uo_out = 8'b0100_0001 (uart_tx=1, sclk=1, all else 0). rx_byte, rx_word, tx_word = 0; all FSMs idle.

## Timing
- UART RX FSM: IDLE→START (verify low at half period)→DATA×8→STOP→IDLE.
  - Start glitch (high at mid-start) returns to IDLE.
  - uart_rx_valid rises at mid-stop plus 2 synchronizer cycles.
- UART TX FSM: IDLE→START→DATA×8→STOP→IDLE.
  - uart_tx falls 1 cycle after the synchronized start is seen.
  - uart_tx_done rises at the cycle the stop period expires.
- SPI FSM: IDLE→LOW (half-period)→HIGH (half-period)→… ×16→DONE (1 cycle)→IDLE.
  - First SCLK fall one half-period after launch.
- Simultaneous spi_rx_start/spi_tx_start is a single full-duplex transfer.
- cs_bar is checked at launch only. Dropping it mid-transfer does not abort.
- rst mid-frame returns every FSM to IDLE and outputs to reset values on the next edge.

## Structure
- `uart_spi_pkg`: freq_control lookup functions for UART bit period and SCLK half-period, FSM state enums, pin index constants.
- One sub-module `uart_spi_uart` (RX+TX, bit-period input); SPI engine and pin mapping live in the top.

## Test plan
- freq=10, loopback=0: drive 0xA5 on ui_in[2] at 1000 ns/bit → uo_out[2]=1 stays high; rx_byte=0xA5.
- Pulse ui_in[3] one cycle → uo_out[0] sends 0, 1,0,1,0,0,1,0,1, 1 at 1000 ns/bit; uo_out[3]=1 after stop.
- freq=01, cs_bar=1, pulse uio_in[0]; drive 0xA55A MSB-first on ui_in[5], changing on SCLK falls → 16 SCLK periods of 40 ns, uo_out[4]=1, rx_word=0xA55A.
- Then pulse uio_in[1] → MISO shows 0xA55A sampled on SCLK rises; uo_out[5]=1.
- cs_bar=0 + uio_in[0] pulse → SCLK stays 1, spi_busy stays 0.
- loopback=1, uio_in[0]+uio_in[1] together → rx_word equals previous tx_word; assert rst mid-transfer → uo_out=0x41 next cycle.

Source files
------------

// File: rtl/uart_spi_pkg.sv
`timescale 1ns/1ps
// Shared rate tables, FSM state types and pin positions for the uart_spi I/O block.
package uart_spi_pkg;

  localparam int UI_RX     = 2;
  localparam int UI_TX_GO  = 3;
  localparam int UI_CS     = 4;
  localparam int UI_MOSI   = 5;
  localparam int UI_LOOP   = 7;
  localparam int UIO_SPI_RX = 0;
  localparam int UIO_SPI_TX = 1;

  // rx pin idles high; resetting its synchronizer low would fake a start edge
  localparam logic [7:0] UI_SYNC_RST = 8'h04;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} spi_state_e;

  function automatic logic [12:0] uart_bit_period(input logic [1:0] f);
    case (f)
      2'b00:   return 13'd5208;
      2'b01:   return 13'd434;
      2'b10:   return 13'd50;
      default: return 13'd25;
    endcase
  endfunction

  function automatic logic [3:0] spi_half_period(input logic [1:0] f);
    case (f)
      2'b00:   return 4'd8;
      2'b01:   return 4'd1;
      2'b10:   return 4'd4;
      default: return 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/uart_spi_uart.sv
`timescale 1ns/1ps
// UART RX (mid-bit sampling, sticky valid) and TX echoing the last received byte.
// Rate latched per frame; a start request while TX is busy is dropped.
module uart_spi_uart
  import uart_spi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [12:0] bit_period_i,
  input  logic        rx_i,
  input  logic        tx_start_i,
  output logic        tx_o,
  output logic        rx_valid_o,
  output logic        tx_done_o
);

  uart_state_e rx_st_q, rx_st_d, tx_st_q, tx_st_d;
  logic [12:0] rx_per_q, rx_per_d, rx_cnt_q, rx_cnt_d;
  logic [12:0] tx_per_q, tx_per_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d, tx_sh_q, tx_sh_d;
  logic        rx_prev_q, rx_prev_d, rx_vld_q, rx_vld_d;
  logic        tx_q, tx_d, tx_done_q, tx_done_d;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_per_d  = rx_per_q;
    rx_cnt_d  = rx_cnt_q + 13'd1;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    rx_vld_d  = rx_vld_q;
    rx_prev_d = rx_i;
    case (rx_st_q)
      U_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_i) begin
          rx_st_d  = U_START;
          rx_per_d = bit_period_i;
          rx_vld_d = 1'b0;
        end
      end
      U_START: if (rx_cnt_q == (rx_per_q >> 1) - 13'd1) begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        rx_st_d  = rx_i ? U_IDLE : U_DATA;
      end
      U_DATA: if (rx_cnt_q == rx_per_q - 13'd1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_i, rx_sh_q[7:1]};
        rx_idx_d = rx_idx_q + 3'd1;
        if (rx_idx_q == 3'd7) rx_st_d = U_STOP;
      end
      default: if (rx_cnt_q == rx_per_q - 13'd1) begin
        rx_st_d = U_IDLE;
        if (rx_i) begin
          rx_byte_d = rx_sh_q;
          rx_vld_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_per_d  = tx_per_q;
    tx_cnt_d  = tx_cnt_q + 13'd1;
    tx_idx_d  = tx_idx_q;
    tx_sh_d   = tx_sh_q;
    tx_d      = tx_q;
    tx_done_d = tx_done_q;
    case (tx_st_q)
      U_IDLE: begin
        tx_cnt_d = '0;
        if (tx_start_i) begin
          tx_st_d   = U_START;
          tx_per_d  = bit_period_i;
          tx_sh_d   = rx_byte_q;
          tx_done_d = 1'b0;
          tx_d      = 1'b0;
        end
      end
      U_START: if (tx_cnt_q == tx_per_q - 13'd1) begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        tx_st_d  = U_DATA;
        tx_d     = tx_sh_q[0];
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
      end
      U_DATA: if (tx_cnt_q == tx_per_q - 13'd1) begin
        tx_cnt_d = '0;
        tx_idx_d = tx_idx_q + 3'd1;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_idx_q == 3'd7) begin
          tx_st_d = U_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = tx_sh_q[0];
        end
      end
      default: if (tx_cnt_q == tx_per_q - 13'd1) begin
        tx_st_d   = U_IDLE;
        tx_done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_st_q <= U_IDLE;  rx_per_q <= '0;  rx_cnt_q <= '0;  rx_idx_q <= '0;
      rx_sh_q <= '0;      rx_byte_q <= '0; rx_vld_q <= 1'b0; rx_prev_q <= 1'b1;
      tx_st_q <= U_IDLE;  tx_per_q <= '0;  tx_cnt_q <= '0;  tx_idx_q <= '0;
      tx_sh_q <= '0;      tx_q <= 1'b1;    tx_done_q <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d; rx_per_q <= rx_per_d; rx_cnt_q <= rx_cnt_d; rx_idx_q <= rx_idx_d;
      rx_sh_q <= rx_sh_d; rx_byte_q <= rx_byte_d; rx_vld_q <= rx_vld_d; rx_prev_q <= rx_prev_d;
      tx_st_q <= tx_st_d; tx_per_q <= tx_per_d; tx_cnt_q <= tx_cnt_d; tx_idx_q <= tx_idx_d;
      tx_sh_q <= tx_sh_d; tx_q <= tx_d;         tx_done_q <= tx_done_d;
    end
  end

  assign tx_o       = tx_q;
  assign rx_valid_o = rx_vld_q;
  assign tx_done_o  = tx_done_q;

endmodule

// File: rtl/uart_spi.sv
`timescale 1ns/1ps
// Pin-level top: input synchronizers, UART echo engine, 16-bit SPI shift engine.
// SPI launch needs cs_bar high and an idle engine; requests otherwise are dropped.
module uart_spi
  import uart_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] ui_meta_q, ui_s_q, uio_meta_q, uio_s_q;
  logic       uart_tx, uart_rx_vld, uart_tx_done, uart_rx_in;
  logic       mosi_in, spi_rx_go, spi_tx_go, spi_busy;
  logic       unused_pins;

  spi_state_e  spi_st_q, spi_st_d;
  logic [3:0]  half_q, half_d, cnt_q, cnt_d, bit_q, bit_d;
  logic [15:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_word_q, rx_word_d;
  logic        rx_req_q, rx_req_d, tx_req_q, tx_req_d;
  logic        sclk_q, sclk_d, miso_q, miso_d;
  logic        spi_rx_vld_q, spi_rx_vld_d, spi_tx_done_q, spi_tx_done_d;

  assign unused_pins = ^{ena, ui_s_q[6], uio_s_q[7:2]};
  assign uart_rx_in  = ui_s_q[UI_LOOP] ? uart_tx : ui_s_q[UI_RX];
  assign mosi_in     = ui_s_q[UI_LOOP] ? miso_q  : ui_s_q[UI_MOSI];
  assign spi_rx_go   = uio_s_q[UIO_SPI_RX];
  assign spi_tx_go   = uio_s_q[UIO_SPI_TX];

  uart_spi_uart u_uart (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_period_i (uart_bit_period(ui_s_q[1:0])),
    .rx_i         (uart_rx_in),
    .tx_start_i   (ui_s_q[UI_TX_GO]),
    .tx_o         (uart_tx),
    .rx_valid_o   (uart_rx_vld),
    .tx_done_o    (uart_tx_done)
  );

  always_comb begin
    spi_st_d      = spi_st_q;
    half_d        = half_q;
    cnt_d         = cnt_q + 4'd1;
    bit_d         = bit_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    rx_word_d     = rx_word_q;
    rx_req_d      = rx_req_q;
    tx_req_d      = tx_req_q;
    sclk_d        = sclk_q;
    miso_d        = miso_q;
    spi_rx_vld_d  = spi_rx_vld_q;
    spi_tx_done_d = spi_tx_done_q;
    case (spi_st_q)
      S_IDLE: begin
        cnt_d = '0;
        if ((spi_rx_go || spi_tx_go) && ui_s_q[UI_CS]) begin
          spi_st_d = S_HIGH;
          half_d   = spi_half_period(ui_s_q[1:0]);
          rx_req_d = spi_rx_go;
          tx_req_d = spi_tx_go;
          tx_sh_d  = rx_word_q;
          bit_d    = '0;
          if (spi_rx_go) spi_rx_vld_d  = 1'b0;
          if (spi_tx_go) spi_tx_done_d = 1'b0;
        end
      end
      S_HIGH: if (cnt_q == half_q - 4'd1) begin
        cnt_d    = '0;
        spi_st_d = S_LOW;
        sclk_d   = 1'b0;
        miso_d   = tx_sh_q[15];
        tx_sh_d  = {tx_sh_q[14:0], 1'b0};
      end
      S_LOW: if (cnt_q == half_q - 4'd1) begin
        cnt_d    = '0;
        sclk_d   = 1'b1;
        rx_sh_d  = {rx_sh_q[14:0], mosi_in};
        bit_d    = bit_q + 4'd1;
        spi_st_d = (bit_q == 4'd15) ? S_DONE : S_HIGH;
      end
      default: begin
        spi_st_d = S_IDLE;
        miso_d   = 1'b0;
        if (rx_req_q) begin
          rx_word_d    = rx_sh_q;
          spi_rx_vld_d = 1'b1;
        end
        if (tx_req_q) spi_tx_done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ui_meta_q <= UI_SYNC_RST; ui_s_q <= UI_SYNC_RST;
      uio_meta_q <= '0;         uio_s_q <= '0;
      spi_st_q <= S_IDLE; half_q <= '0; cnt_q <= '0; bit_q <= '0;
      tx_sh_q <= '0; rx_sh_q <= '0; rx_word_q <= '0;
      rx_req_q <= 1'b0; tx_req_q <= 1'b0; sclk_q <= 1'b1; miso_q <= 1'b0;
      spi_rx_vld_q <= 1'b0; spi_tx_done_q <= 1'b0;
    end else begin
      ui_meta_q <= ui_in;   ui_s_q <= ui_meta_q;
      uio_meta_q <= uio_in; uio_s_q <= uio_meta_q;
      spi_st_q <= spi_st_d; half_q <= half_d; cnt_q <= cnt_d; bit_q <= bit_d;
      tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d; rx_word_q <= rx_word_d;
      rx_req_q <= rx_req_d; tx_req_q <= tx_req_d; sclk_q <= sclk_d; miso_q <= miso_d;
      spi_rx_vld_q <= spi_rx_vld_d; spi_tx_done_q <= spi_tx_done_d;
    end
  end

  assign spi_busy = (spi_st_q == S_HIGH) || (spi_st_q == S_LOW);
  assign uo_out   = {spi_busy, sclk_q, spi_tx_done_q, spi_rx_vld_q,
                     uart_tx_done, uart_rx_vld, miso_q, uart_tx};
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;

endmodule

// File: tb/tb_uart_spi.sv
`timescale 1ns/1ps
// Directed bench for uart_spi: UART echo, SPI capture/echo, cs gating, loopback, reset.
module tb_uart_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'b0001_0110;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_spi dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_uo(input int idx, input logic lvl, input string what);
    int n = 0;
    while (uo_out[idx] !== lvl && n < 400) begin
      tick();
      n++;
    end
    if (uo_out[idx] !== lvl) begin
      total_cnt++;
      $display("FAIL %s: timeout, uo_out[%0d] never reached %0b", what, idx, lvl);
    end
  endtask

  task automatic pulse_uio(input logic [7:0] v);
    uio_in = v;
    tick();
    uio_in = 8'h00;
  endtask

  task automatic spi_capture(output logic [15:0] w);
    w = '0;
    for (int k = 0; k < 16; k++) begin
      wait_uo(6, 1'b0, "sclk_fall");
      wait_uo(6, 1'b1, "sclk_rise");
      w[15-k] = uo_out[1];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (uo_out !== 8'h41) $display("FAIL reset_uo_out: got %h want 41", uo_out);
    else pass_cnt++;
    total_cnt++;
    if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h want 00", uio_out);
    else pass_cnt++;
    total_cnt++;
    if (uio_oe !== 8'h00) $display("FAIL reset_uio_oe: got %h want 00", uio_oe);
    else pass_cnt++;
  endtask

  task automatic test_uart_rx();
    logic [9:0] fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ui_in[2] = fr[i];
      repeat (50) tick();
    end
    ui_in[2] = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (uo_out[2] !== 1'b1) $display("FAIL uart_rx_valid: got %b want 1", uo_out[2]);
    else pass_cnt++;
  endtask

  task automatic test_uart_tx();
    logic [9:0] got = '0;
    ui_in[3] = 1'b1;
    tick();
    ui_in[3] = 1'b0;
    wait_uo(0, 1'b0, "uart_tx_start_bit");
    repeat (25) tick();
    got[0] = uo_out[0];
    for (int i = 1; i < 10; i++) begin
      repeat (50) tick();
      got[i] = uo_out[0];
    end
    total_cnt++;
    if (uo_out[3] !== 1'b0) $display("FAIL uart_tx_done_mid: got %b want 0", uo_out[3]);
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'b11010_01010) $display("FAIL uart_tx_bits: got %b want 1101001010", got);
    else pass_cnt++;
    repeat (30) tick();
    total_cnt++;
    if (uo_out[3] !== 1'b1) $display("FAIL uart_tx_done_end: got %b want 1", uo_out[3]);
    else pass_cnt++;
  endtask

  task automatic test_uart_bad_stop();
    logic [9:0] fr = {1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ui_in[2] = fr[i];
      repeat (50) tick();
      if (i == 0) begin
        total_cnt++;
        if (uo_out[2] !== 1'b0) $display("FAIL uart_rx_valid_clear: got %b want 0", uo_out[2]);
        else pass_cnt++;
      end
    end
    ui_in[2] = 1'b1;
    repeat (60) tick();
    total_cnt++;
    if (uo_out[2] !== 1'b0) $display("FAIL uart_bad_stop: got %b want 0", uo_out[2]);
    else pass_cnt++;
  endtask

  task automatic test_spi_rx();
    logic [15:0] w = 16'hA55A;
    time t0 = 0;
    time t15 = 0;
    ui_in[1:0] = 2'b01;
    ui_in[5] = w[15];
    pulse_uio(8'h01);
    for (int k = 0; k < 16; k++) begin
      wait_uo(6, 1'b1, "spi_rx_high");
      wait_uo(6, 1'b0, "spi_rx_fall");
      if (k == 0) t0 = $time;
      if (k == 15) t15 = $time;
      if (k < 15) ui_in[5] = w[14-k];
    end
    total_cnt++;
    if (t15 - t0 !== 600) $display("FAIL spi_sclk_period: 15 periods took %0t want 600 ns", t15 - t0);
    else pass_cnt++;
    wait_uo(7, 1'b0, "spi_rx_busy_drop");
    repeat (3) tick();
    total_cnt++;
    if (uo_out[4] !== 1'b1) $display("FAIL spi_rx_valid: got %b want 1", uo_out[4]);
    else pass_cnt++;
    total_cnt++;
    if (uo_out[5] !== 1'b0) $display("FAIL spi_rx_only_tx_done: got %b want 0", uo_out[5]);
    else pass_cnt++;
    total_cnt++;
    if (uo_out[7:6] !== 2'b01) $display("FAIL spi_idle_pins: busy/sclk got %b want 01", uo_out[7:6]);
    else pass_cnt++;
  endtask

  task automatic test_spi_tx();
    logic [15:0] got;
    pulse_uio(8'h02);
    spi_capture(got);
    total_cnt++;
    if (got !== 16'hA55A) $display("FAIL spi_miso_word: got %h want a55a", got);
    else pass_cnt++;
    wait_uo(7, 1'b0, "spi_tx_busy_drop");
    repeat (3) tick();
    total_cnt++;
    if (uo_out[5] !== 1'b1) $display("FAIL spi_tx_done: got %b want 1", uo_out[5]);
    else pass_cnt++;
    total_cnt++;
    if (uo_out[4] !== 1'b1) $display("FAIL spi_tx_keeps_rx_valid: got %b want 1", uo_out[4]);
    else pass_cnt++;
    total_cnt++;
    if (uo_out[1] !== 1'b0) $display("FAIL spi_miso_idle: got %b want 0", uo_out[1]);
    else pass_cnt++;
  endtask

  task automatic test_cs_gate();
    logic moved = 1'b0;
    ui_in[4] = 1'b0;
    pulse_uio(8'h01);
    for (int i = 0; i < 30; i++) begin
      if (uo_out[6] !== 1'b1 || uo_out[7] !== 1'b0) moved = 1'b1;
      tick();
    end
    total_cnt++;
    if (moved !== 1'b0) $display("FAIL cs_gate_sclk_busy: activity seen %b want 0", moved);
    else pass_cnt++;
    total_cnt++;
    if (uo_out[4] !== 1'b1) $display("FAIL cs_gate_rx_valid: got %b want 1", uo_out[4]);
    else pass_cnt++;
    ui_in[4] = 1'b1;
  endtask

  task automatic test_loopback();
    logic [15:0] got;
    ui_in[7] = 1'b1;
    ui_in[5] = 1'b0;
    repeat (3) tick();
    pulse_uio(8'h03);
    spi_capture(got);
    total_cnt++;
    if (got !== 16'hA55A) $display("FAIL loop_miso_word: got %h want a55a", got);
    else pass_cnt++;
    wait_uo(7, 1'b0, "loop_busy_drop");
    repeat (3) tick();
    total_cnt++;
    if (uo_out[5:4] !== 2'b11) $display("FAIL loop_flags: done/valid got %b want 11", uo_out[5:4]);
    else pass_cnt++;
    ui_in[7] = 1'b0;
    repeat (3) tick();
    pulse_uio(8'h02);
    spi_capture(got);
    total_cnt++;
    if (got !== 16'hA55A) $display("FAIL loop_rx_word: got %h want a55a", got);
    else pass_cnt++;
    wait_uo(7, 1'b0, "loop_read_busy_drop");
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    pulse_uio(8'h02);
    wait_uo(7, 1'b1, "rst_mid_busy");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (uo_out !== 8'h41) $display("FAIL rst_mid_uo_out: got %h want 41", uo_out);
    else pass_cnt++;
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if (uo_out !== 8'h41) $display("FAIL rst_after_idle: got %h want 41", uo_out);
    else pass_cnt++;
    pulse_uio(8'h02);
    spi_capture(got);
    total_cnt++;
    if (got !== 16'h0000) $display("FAIL rst_rx_word_cleared: got %h want 0000", got);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_uart_rx();
    test_uart_tx();
    test_uart_bad_stop();
    test_spi_rx();
    test_spi_tx();
    test_cs_gate();
    test_loopback();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
